spi_regfile_peripheral: RTL and testbench
=========================================

Name: spi_regfile_peripheral

Overview:
Parametrised SPI mode-0 peripheral with a register file that can be both written and read back. It is the next generation of the fixed 5x8-bit write-only SPI register block, generalised in address width, data width and register count. It adds read frames on CIPO, abort on early CS release and a write strobe. It sits between the chip-level SPI pins and the PWM/output-enable logic, which consumes the flattened register bus.

Parameters:
ADDR_W, 7, address field width in bits
DATA_W, 8, data field / register width in bits
NUM_REGS, 5, implemented registers at addresses 0..NUM_REGS-1 (1 <= NUM_REGS <= 2^ADDR_W)
RESET_VAL, 0, reset value applied to every register (DATA_W bits)

Ports:
clk  input  1  system clock; all logic on posedge
rst_n  input  1  synchronous active-low reset, sampled on posedge clk
sclk  input  1  SPI clock, asynchronous to clk
copi  input  1  controller-out peripheral-in, asynchronous
cs  input  1  chip select, active low, asynchronous
cipo  output  1  peripheral-out controller-in data
cipo_oe  output  1  output enable for the cipo pad driver
regs_out  output  NUM_REGS*DATA_W  flattened registers; reg k occupies bits [k*DATA_W +: DATA_W]
wr_strobe  output  1  one-clk pulse when a register is written
wr_addr  output  ADDR_W  address of the most recent committed write

Behaviour:
- Synchronisation:
  - sclk, copi and cs each pass through a 2-flop synchroniser.
  - sclk and cs also get a third "prev" flop for edge detection.
  - Reset values: sclk/copi chains 0, cs chain 1.
- Frame format, MSB first, length 1+ADDR_W+DATA_W bits:
  - bit 0: R/W, where 1 = write and 0 = read.
  - next ADDR_W bits: address.
  - last DATA_W bits: data.
- Timing:
  - copi is sampled on a synchronised sclk rising edge.
  - cipo is updated on a synchronised sclk falling edge.
  - Supported sclk frequency is at most clk/8.
- FSM states:
  - IDLE: waiting for a frame; cs_sync high.
  - CMD: waiting for the R/W bit.
  - ADDR: shifting in the address.
  - DATA: shifting data in (write) or out (read).
  - COMMIT: one clk, applies the write.
  - WAIT_CS: frame complete; waiting for CS release.
- FSM transitions:
  - IDLE -> CMD on cs falling edge; bit counter cleared, shift register cleared.
  - CMD -> ADDR after the R/W bit is sampled.
  - ADDR -> DATA after ADDR_W address bits are sampled.
  - DATA -> COMMIT after DATA_W bits are sampled in a write frame.
  - DATA -> WAIT_CS after DATA_W bits are sampled in a read frame.
  - COMMIT -> WAIT_CS after one clk.
  - WAIT_CS -> IDLE on cs rising edge.
- Write commit:
  - Happens in COMMIT, one clk after the clk cycle that sampled the last data bit.
  - If addr < NUM_REGS: the register is updated, wr_strobe=1 for exactly that clk, and wr_addr takes addr.
  - If addr >= NUM_REGS: no register change, no strobe, wr_addr unchanged.
- Read:
  - On the clk where the last address bit is sampled, the output shift register loads reg[addr], or all zeros if addr >= NUM_REGS.
  - cipo shows the MSB from the next clk.
  - Each following sclk falling edge in DATA shifts out the next bit.
  - Register contents are snapshotted at load time; a concurrent write cannot occur, since there is only one port.
- cipo_oe and idle level:
  - cipo_oe=1 only in DATA of a read frame, and in WAIT_CS after a read frame until cs rises.
  - Whenever cipo_oe=0, cipo is driven 0.
- Abort:
  - A cs rising edge in any of CMD, ADDR or DATA returns the FSM to IDLE.
  - No commit, no strobe, and cipo_oe drops on the same clk.
- Extra sclk edges in WAIT_CS are ignored; there is no second frame within one CS assertion.
- A cs falling edge while not in IDLE or WAIT_CS cannot occur, because a rising edge is required first.
- Reset, synchronous:
  - Every register returns to RESET_VAL.
  - cipo=0, cipo_oe=0, wr_strobe=0, wr_addr=0, FSM in IDLE.
  - Reset overrides everything, including a frame in progress; no partial commit.
- The bit counter is $clog2(1+ADDR_W+DATA_W+1) bits wide.

Optional Feature:
SPI_ERR_CNT_EN
- Defined:
  - Adds output err_count [7:0], reset 0.
  - Increments once per aborted frame (cs rises in CMD, ADDR or DATA).
  - Increments once per write to an address >= NUM_REGS.
  - Saturates at 255.
  - Reading address 2^ADDR_W-1 returns err_count zero-extended to DATA_W, provided that address is >= NUM_REGS; otherwise the normal register is returned.
- Not defined:
  - No err_count port.
  - Counter logic absent.
  - Out-of-range reads return 0.

Test Plan:
- Reset, then write frame 1,0x04,0xA5 -> regs_out[39:32]=0xA5; wr_strobe high 1 clk; wr_addr=4; all other registers 0.
- Write 0x5A to address 2, then read frame 0,0x02 -> cipo shifts out 0x5A MSB first; cipo_oe high only during data phase through CS release.
- Write frame to address 0x10 -> no register change, no wr_strobe. With SPI_ERR_CNT_EN: err_count=1; reading 0x7F returns 0x01.
- cs raised after 10 of 16 bits of a write to address 1 -> reg1 unchanged, no strobe, FSM in IDLE. A following complete frame to address 1 commits correctly.
- 20 sclk pulses in one CS assertion writing 0x33 to address 3 -> only the first 16 bits are used; reg3=0x33; one strobe.
- rst_n low mid-frame after prior writes -> all registers return to RESET_VAL. With the parameter override ADDR_W=3, DATA_W=16, NUM_REGS=8, a 20-bit write of 0xBEEF to address 7 lands in regs_out[127:112].

Source files
------------

// File: rtl/spi_regfile_peripheral_if.sv
// rtl/spi_regfile_peripheral_if.sv - SPI pin bundle between a controller and the register-file peripheral.
interface spi_regfile_peripheral_if;
  logic sclk;
  logic copi;
  logic cs;
  logic cipo;
  logic cipo_oe;

  modport master (output sclk, output copi, output cs, input cipo, input cipo_oe);
  modport slave  (input sclk, input copi, input cs, output cipo, output cipo_oe);
endinterface

// File: rtl/spi_regfile_peripheral.sv
// rtl/spi_regfile_peripheral.sv - SPI mode-0 read/write register file with write strobe.
// Optional SPI_ERR_CNT_EN adds a saturating error counter readable at the top address.
module spi_regfile_peripheral #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int NUM_REGS = 5,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic clk,
  input  logic rst_n,
  spi_regfile_peripheral_if.slave spi,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic wr_strobe,
  output logic [ADDR_W-1:0] wr_addr
`ifdef SPI_ERR_CNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam int CNT_W = $clog2(1 + ADDR_W + DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] FIRST_DATA = CNT_W'(ADDR_W + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(ADDR_W + DATA_W);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, COMMIT, WAIT_CS} state_t;

  state_t state, state_next;
  logic [1:0] sclk_sync, copi_sync, cs_sync;
  logic sclk_prev, cs_prev;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [CNT_W-1:0] bit_cnt;
  logic rw;
  logic [ADDR_W-1:0] addr_sh, addr_next;
  logic [DATA_W-1:0] data_sh, out_sh, rd_data;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic addr_in_range, read_active, abort;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync <= 2'b00;
      copi_sync <= 2'b00;
      cs_sync   <= 2'b11;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[0], spi.sclk};
      copi_sync <= {copi_sync[0], spi.copi};
      cs_sync   <= {cs_sync[0], spi.cs};
      sclk_prev <= sclk_sync[1];
      cs_prev   <= cs_sync[1];
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_prev;
  assign sclk_fall = ~sclk_sync[1] & sclk_prev;
  assign cs_rise   = cs_sync[1] & ~cs_prev;
  assign cs_fall   = ~cs_sync[1] & cs_prev;

  assign addr_next     = (addr_sh << 1) | ADDR_W'(copi_sync[1]);
  assign addr_in_range = 32'(addr_sh) < NUM_REGS;
  assign abort         = cs_rise && (state == CMD || state == ADDR || state == DATA);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cs_fall) state_next = CMD;
      CMD:     if (cs_rise) state_next = IDLE;
               else if (sclk_rise) state_next = ADDR;
      ADDR:    if (cs_rise) state_next = IDLE;
               else if (sclk_rise && bit_cnt == LAST_ADDR) state_next = DATA;
      DATA:    if (cs_rise) state_next = IDLE;
               else if (sclk_rise && bit_cnt == LAST_DATA) state_next = rw ? COMMIT : WAIT_CS;
      // A CS release landing on the commit clk must not strand the FSM in WAIT_CS.
      COMMIT:  state_next = cs_rise ? IDLE : WAIT_CS;
      WAIT_CS: if (cs_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (addr_next == ADDR_W'(k)) rd_data = regs[k];
`ifdef SPI_ERR_CNT_EN
    if (addr_next == {ADDR_W{1'b1}} && 32'(addr_next) >= NUM_REGS) rd_data = DATA_W'(err_count);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      rw        <= 1'b0;
      addr_sh   <= '0;
      data_sh   <= '0;
      out_sh    <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= RESET_VAL;
    end else begin
      wr_strobe <= 1'b0;
      case (state)
        IDLE: if (cs_fall) begin
          bit_cnt <= '0;
          rw      <= 1'b0;
          addr_sh <= '0;
          data_sh <= '0;
        end
        CMD: if (!cs_rise && sclk_rise) begin
          rw      <= copi_sync[1];
          bit_cnt <= bit_cnt + 1'b1;
        end
        ADDR: if (!cs_rise && sclk_rise) begin
          addr_sh <= addr_next;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_ADDR && !rw) out_sh <= rd_data;
        end
        DATA: if (!cs_rise) begin
          if (sclk_rise) begin
            if (rw) data_sh <= (data_sh << 1) | DATA_W'(copi_sync[1]);
            bit_cnt <= bit_cnt + 1'b1;
          // The falling edge right after the last address bit keeps the MSB on the pin.
          end else if (sclk_fall && !rw && bit_cnt > FIRST_DATA) begin
            out_sh <= out_sh << 1;
          end
        end
        COMMIT: if (addr_in_range) begin
          for (int k = 0; k < NUM_REGS; k++)
            if (addr_sh == ADDR_W'(k)) regs[k] <= data_sh;
          wr_strobe <= 1'b1;
          wr_addr   <= addr_sh;
        end
        default: ;
      endcase
    end
  end

`ifdef SPI_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      err_count <= 8'd0;
    else if ((abort || (state == COMMIT && !addr_in_range)) && err_count != 8'hFF)
      err_count <= err_count + 8'd1;
  end
`endif

  assign read_active = !rw && (state == DATA || state == WAIT_CS);
  assign spi.cipo_oe = read_active && !cs_rise && !abort;
  assign spi.cipo    = spi.cipo_oe ? out_sh[DATA_W-1] : 1'b0;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign regs_out[k*DATA_W +: DATA_W] = regs[k];
  end

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// tb/tb_spi_regfile_peripheral.sv - directed bench for spi_regfile_peripheral (default and wide builds).
module tb_spi_regfile_peripheral;
  localparam time HALF = 50ns;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5ns clk = ~clk;

  spi_regfile_peripheral_if bus0();
  spi_regfile_peripheral_if bus1();

  logic [39:0]  regs0;
  logic [127:0] regs1;
  logic strobe0, strobe1;
  logic [6:0] wr_addr0;
  logic [2:0] wr_addr1;
`ifdef SPI_ERR_CNT_EN
  logic [7:0] err0, err1;
`endif

  spi_regfile_peripheral dut0 (
    .clk(clk), .rst_n(rst_n), .spi(bus0),
    .regs_out(regs0), .wr_strobe(strobe0), .wr_addr(wr_addr0)
`ifdef SPI_ERR_CNT_EN
    , .err_count(err0)
`endif
  );

  spi_regfile_peripheral #(.ADDR_W(3), .DATA_W(16), .NUM_REGS(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .spi(bus1),
    .regs_out(regs1), .wr_strobe(strobe1), .wr_addr(wr_addr1)
`ifdef SPI_ERR_CNT_EN
    , .err_count(err1)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int scnt0 = 0;
  int scnt1 = 0;

  always @(negedge clk) begin
    if (strobe0) scnt0 <= scnt0 + 1;
    if (strobe1) scnt1 <= scnt1 + 1;
  end

  task automatic drive(input int which, input logic s, input logic d, input logic c);
    if (which == 0) begin
      bus0.sclk = s; bus0.copi = d; bus0.cs = c;
    end else begin
      bus1.sclk = s; bus1.copi = d; bus1.cs = c;
    end
  endtask

  // Bits past nbits are driven high so ignored trailing clocks would corrupt data if used.
  task automatic spi_xfer(input int which, input logic [31:0] frame, input int nbits, input int npulses,
                          input int naddr, output logic [31:0] rx, output logic [31:0] oe_bits,
                          output logic oe_end);
    logic d;
    rx = '0;
    oe_bits = '0;
    @(negedge clk);
    for (int i = 0; i < npulses; i++) begin
      d = (i < nbits) ? frame[nbits-1-i] : 1'b1;
      drive(which, 1'b0, d, 1'b0);
      #HALF;
      oe_bits[i] = bus0.cipo_oe;
      if (i > naddr && i < nbits) rx = {rx[30:0], bus0.cipo};
      drive(which, 1'b1, d, 1'b0);
      #HALF;
      drive(which, 1'b0, d, 1'b0);
    end
    #HALF;
    oe_end = bus0.cipo_oe;
    drive(which, 1'b0, 1'b0, 1'b1);
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++; if (regs0 !== 40'h0) begin n_bad++; $display("FAIL reset_regs0: got %h want %h", regs0, 40'h0); end
    n_cmp++; if (strobe0 !== 1'b0) begin n_bad++; $display("FAIL reset_strobe: got %b want 0", strobe0); end
    n_cmp++; if (wr_addr0 !== 7'h0) begin n_bad++; $display("FAIL reset_wr_addr: got %h want 0", wr_addr0); end
    n_cmp++; if (bus0.cipo !== 1'b0 || bus0.cipo_oe !== 1'b0) begin
      n_bad++; $display("FAIL reset_cipo: got cipo=%b oe=%b want 0/0", bus0.cipo, bus0.cipo_oe); end
    n_cmp++; if (regs1 !== 128'h0) begin n_bad++; $display("FAIL reset_regs1: got %h want 0", regs1); end
  endtask

  task automatic test_write_basic;
    logic [31:0] rx, oe;
    logic oe_end;
    spi_xfer(0, 32'h84A5, 16, 16, 7, rx, oe, oe_end);
    n_cmp++; if (regs0 !== 40'hA5_00_00_00_00) begin n_bad++; $display("FAIL write4_regs: got %h want %h", regs0, 40'hA500000000); end
    n_cmp++; if (scnt0 !== 1) begin n_bad++; $display("FAIL write4_strobe_cycles: got %0d want 1", scnt0); end
    n_cmp++; if (wr_addr0 !== 7'h04) begin n_bad++; $display("FAIL write4_wr_addr: got %h want 04", wr_addr0); end
  endtask

  task automatic test_read;
    logic [31:0] rx, oe;
    logic oe_end;
    spi_xfer(0, 32'h825A, 16, 16, 7, rx, oe, oe_end);
    n_cmp++; if (regs0 !== 40'hA5_00_5A_00_00) begin n_bad++; $display("FAIL write2_regs: got %h want %h", regs0, 40'hA5005A0000); end
    spi_xfer(0, 32'h0200, 16, 16, 7, rx, oe, oe_end);
    n_cmp++; if (rx[7:0] !== 8'h5A) begin n_bad++; $display("FAIL read2_data: got %h want 5a", rx[7:0]); end
    n_cmp++; if (oe !== 32'h0000_FF00) begin n_bad++; $display("FAIL read2_oe_pattern: got %h want 0000ff00", oe); end
    n_cmp++; if (oe_end !== 1'b1) begin n_bad++; $display("FAIL read2_oe_wait_cs: got %b want 1", oe_end); end
    n_cmp++; if (bus0.cipo_oe !== 1'b0 || bus0.cipo !== 1'b0) begin
      n_bad++; $display("FAIL read2_oe_after_cs: got oe=%b cipo=%b want 0/0", bus0.cipo_oe, bus0.cipo); end
    spi_xfer(0, 32'h0400, 16, 16, 7, rx, oe, oe_end);
    n_cmp++; if (rx[7:0] !== 8'hA5) begin n_bad++; $display("FAIL read4_data: got %h want a5", rx[7:0]); end
    n_cmp++; if (scnt0 !== 2) begin n_bad++; $display("FAIL read_no_strobe: got %0d want 2", scnt0); end
  endtask

  task automatic test_out_of_range;
    logic [31:0] rx, oe;
    logic oe_end;
    logic [7:0] exp_top;
    spi_xfer(0, 32'h90FF, 16, 16, 7, rx, oe, oe_end);
    n_cmp++; if (regs0 !== 40'hA5_00_5A_00_00) begin n_bad++; $display("FAIL oor_regs: got %h want %h", regs0, 40'hA5005A0000); end
    n_cmp++; if (scnt0 !== 2) begin n_bad++; $display("FAIL oor_strobe: got %0d want 2", scnt0); end
    n_cmp++; if (wr_addr0 !== 7'h02) begin n_bad++; $display("FAIL oor_wr_addr: got %h want 02", wr_addr0); end
    spi_xfer(0, 32'h1000, 16, 16, 7, rx, oe, oe_end);
    n_cmp++; if (rx[7:0] !== 8'h00) begin n_bad++; $display("FAIL oor_read: got %h want 00", rx[7:0]); end
`ifdef SPI_ERR_CNT_EN
    exp_top = 8'h01;
    n_cmp++; if (err0 !== 8'h01) begin n_bad++; $display("FAIL err_count_oor: got %h want 01", err0); end
`else
    exp_top = 8'h00;
`endif
    spi_xfer(0, 32'h7F00, 16, 16, 7, rx, oe, oe_end);
    n_cmp++; if (rx[7:0] !== exp_top) begin n_bad++; $display("FAIL read_top_addr: got %h want %h", rx[7:0], exp_top); end
  endtask

  task automatic test_abort;
    logic [31:0] rx, oe;
    logic oe_end;
    spi_xfer(0, 32'h8177, 16, 10, 7, rx, oe, oe_end);
    n_cmp++; if (regs0 !== 40'hA5_00_5A_00_00) begin n_bad++; $display("FAIL abort_regs: got %h want %h", regs0, 40'hA5005A0000); end
    n_cmp++; if (scnt0 !== 2) begin n_bad++; $display("FAIL abort_strobe: got %0d want 2", scnt0); end
    n_cmp++; if (oe_end !== 1'b0) begin n_bad++; $display("FAIL abort_oe: got %b want 0", oe_end); end
`ifdef SPI_ERR_CNT_EN
    n_cmp++; if (err0 !== 8'h02) begin n_bad++; $display("FAIL err_count_abort: got %h want 02", err0); end
`endif
    spi_xfer(0, 32'h813C, 16, 16, 7, rx, oe, oe_end);
    n_cmp++; if (regs0 !== 40'hA5_00_5A_3C_00) begin n_bad++; $display("FAIL after_abort_regs: got %h want %h", regs0, 40'hA5005A3C00); end
    n_cmp++; if (scnt0 !== 3 || wr_addr0 !== 7'h01) begin
      n_bad++; $display("FAIL after_abort_strobe: got cnt=%0d addr=%h want 3/01", scnt0, wr_addr0); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rx, oe;
    logic oe_end;
    spi_xfer(0, 32'h8333, 16, 20, 7, rx, oe, oe_end);
    n_cmp++; if (regs0 !== 40'hA5_33_5A_3C_00) begin n_bad++; $display("FAIL extra_clk_regs: got %h want %h", regs0, 40'hA5335A3C00); end
    n_cmp++; if (scnt0 !== 4 || wr_addr0 !== 7'h03) begin
      n_bad++; $display("FAIL extra_clk_strobe: got cnt=%0d addr=%h want 4/03", scnt0, wr_addr0); end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] rx, oe;
    logic oe_end;
    logic [15:0] frame = 16'h80FF;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      drive(0, 1'b0, frame[15-i], 1'b0);
      #HALF;
      drive(0, 1'b1, frame[15-i], 1'b0);
      #HALF;
    end
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    n_cmp++; if (regs0 !== 40'h0) begin n_bad++; $display("FAIL midframe_reset_regs: got %h want 0", regs0); end
    n_cmp++; if (wr_addr0 !== 7'h0 || bus0.cipo_oe !== 1'b0) begin
      n_bad++; $display("FAIL midframe_reset_outs: got addr=%h oe=%b want 0/0", wr_addr0, bus0.cipo_oe); end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++; if (scnt0 !== 4) begin n_bad++; $display("FAIL midframe_no_commit: got %0d want 4", scnt0); end
    spi_xfer(1, 32'hFBEEF, 20, 20, 3, rx, oe, oe_end);
    n_cmp++; if (regs1 !== {16'hBEEF, 112'h0}) begin n_bad++; $display("FAIL wide_regs: got %h want %h", regs1, {16'hBEEF, 112'h0}); end
    n_cmp++; if (scnt1 !== 1 || wr_addr1 !== 3'd7) begin
      n_bad++; $display("FAIL wide_strobe: got cnt=%0d addr=%0d want 1/7", scnt1, wr_addr1); end
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 1'b1);
    drive(1, 1'b0, 1'b0, 1'b1);
    test_reset();
    test_write_basic();
    test_read();
    test_out_of_range();
    test_abort();
    test_back_to_back();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
